// File: rtl/fpu_seq.sv
// fpu_seq: multicycle single-precision FP execution unit (FADD/FMUL/FSUB).
// Accepts a command in IDLE, then steps UNPACK -> EXEC -> NORM -> PACK and
// returns a registered result/flag pair with a one-cycle done pulse. Rounding
// is truncation; denormal inputs are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      command valid, sampled only in IDLE
//   FPUControl 00 FADD, 01 FMUL, 10 FSUB, 11 reserved
//   SrcA/SrcB  IEEE-754 single operands
//   busy       high UNPACK..PACK
//   done       one-cycle pulse when FPUResult/FPUFlags update
//   FPUResult  registered result
//   FPUFlags   {N,Z,C,V}, registered with FPUResult
module fpu_seq #(
  parameter bit LAT_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  FPUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] FPUResult,
  output logic [3:0]  FPUFlags
);
  localparam logic [1:0]  OP_MUL = 2'b01;
  localparam logic [1:0]  OP_SUB = 2'b10;
  localparam logic [1:0]  OP_RSV = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, PACK} state_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        zero;
    logic        inf;
    logic        nan;
  } opnd_t;

  // Result decided in EXEC that bypasses normalization.
  typedef struct packed {
    logic        vld;
    logic [31:0] res;
    logic [3:0]  flg;
  } spec_t;

  function automatic opnd_t unpack(input logic [31:0] x, input logic flip);
    opnd_t o;
    o.s    = x[31] ^ flip;
    o.e    = x[30:23];
    o.zero = (x[30:23] == 8'd0);
    o.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    o.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    o.m    = o.zero ? 24'd0 : {1'b1, x[22:0]};
    return o;
  endfunction

  // ---------------------------------------------------------------- FSM
  state_t state_q, state_d;
  logic   accept;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE:    if (start) begin accept = 1'b1; state_d = UNPACK; end
      UNPACK:  state_d = EXEC;
      EXEC:    state_d = NORM;
      NORM:    state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------- capture
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_q <= '0; a_q <= '0; b_q <= '0;
    end else if (accept) begin
      op_q <= FPUControl; a_q <= SrcA; b_q <= SrcB;
    end

  // ---------------------------------------------------------------- UNPACK
  // Stage registers advance every cycle; each is only consumed in its state.
  logic [1:0] u_op;
  opnd_t      u_a, u_b;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      u_op <= '0; u_a <= '0; u_b <= '0;
    end else begin
      u_op <= op_q;
      u_a  <= unpack(a_q, 1'b0);
      u_b  <= unpack(b_q, op_q == OP_SUB);  // FSUB = FADD with B negated
    end

  // ---------------------------------------------------------------- EXEC
  logic               is_mul, eff_sub, a_ge_b, big_s, inf_s;
  logic [7:0]         big_e, sml_e, sh_d;
  logic [23:0]        big_m, sml_m;
  logic [49:0]        sh_wide;
  logic [25:0]        sml_al;       // {significand, guard, sticky}
  logic [26:0]        big_al, sum;
  logic [47:0]        prod, x_sig_d;
  logic signed [10:0] mexp, x_exp_d;
  logic               x_sign_d;
  spec_t              spec_d;

  always_comb begin
    is_mul  = (u_op == OP_MUL);
    eff_sub = u_a.s ^ u_b.s;
    a_ge_b  = {u_a.e, u_a.m} >= {u_b.e, u_b.m};
    big_s   = a_ge_b ? u_a.s : u_b.s;
    big_e   = a_ge_b ? u_a.e : u_b.e;
    big_m   = a_ge_b ? u_a.m : u_b.m;
    sml_e   = a_ge_b ? u_b.e : u_a.e;
    sml_m   = a_ge_b ? u_b.m : u_a.m;
    sh_d    = big_e - sml_e;
    // Shift inside a 50-bit window so nothing falls off for sh_d <= 25;
    // everything below the guard position collapses into sticky.
    sh_wide = {sml_m, 26'd0} >> sh_d;
    sml_al  = (sh_d >= 8'd26) ? {25'd0, |sml_m}
                              : {sh_wide[49:25], |sh_wide[24:0]};
    big_al  = {1'b0, big_m, 2'b00};
    sum     = eff_sub ? (big_al - {1'b0, sml_al}) : (big_al + {1'b0, sml_al});
    prod    = {24'd0, u_a.m} * {24'd0, u_b.m};
    mexp    = $signed({3'b000, u_a.e}) + $signed({3'b000, u_b.e}) - 11'sd127;

    // Both paths land with the hidden bit at position 46.
    x_sig_d  = is_mul ? prod : {sum, 21'd0};
    x_exp_d  = is_mul ? mexp : $signed({3'b000, big_e});
    x_sign_d = is_mul ? (u_a.s ^ u_b.s) : big_s;
    inf_s    = is_mul ? (u_a.s ^ u_b.s) : (u_a.inf ? u_a.s : u_b.s);
    spec_d   = '0;

    if (u_op == OP_RSV)
      spec_d = '{1'b1, 32'd0, 4'b0100};
    else if (u_a.nan || u_b.nan)
      spec_d = '{1'b1, QNAN, 4'b0001};
    else if (is_mul ? ((u_a.inf && u_b.zero) || (u_a.zero && u_b.inf))
                    : (u_a.inf && u_b.inf && eff_sub))
      spec_d = '{1'b1, QNAN, 4'b0001};
    else if (u_a.inf || u_b.inf)
      spec_d = '{1'b1, {inf_s, 8'hFF, 23'd0}, {inf_s, 3'b000}};
    else if (!is_mul && (sum == 27'd0))
      spec_d = '{1'b1, 32'd0, 4'b0100};
    else if (is_mul && (u_a.zero || u_b.zero))
      spec_d = '{1'b1, {x_sign_d, 31'd0}, {x_sign_d, 3'b100}};
  end

  logic [47:0]        x_sig;
  logic signed [10:0] x_exp;
  logic               x_sign;
  spec_t              x_spec;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x_sig <= '0; x_exp <= '0; x_sign <= 1'b0; x_spec <= '0;
    end else begin
      x_sig <= x_sig_d; x_exp <= x_exp_d; x_sign <= x_sign_d; x_spec <= spec_d;
    end

  // ---------------------------------------------------------------- NORM
  logic [5:0]         lz;
  logic [45:0]        nm;           // fraction bits below the hidden bit
  logic signed [10:0] n_exp_d;
  logic               lost;

  always_comb begin
    // Upward scan: the last hit is the highest set bit.
    lz = '0;
    for (int i = 0; i <= 46; i++)
      if (x_sig[i]) lz = 6'(46 - i);
    if (x_sig[47]) begin            // carry out: one step right
      nm      = x_sig[46:1];
      n_exp_d = x_exp + 11'sd1;
      lost    = x_sig[0];
    end else begin
      nm      = x_sig[45:0] << lz;
      n_exp_d = x_exp - $signed({5'd0, lz});
      lost    = 1'b0;
    end
  end

  logic [22:0]        n_mant;
  logic signed [10:0] n_exp;
  logic               n_sign, n_inx;
  spec_t              n_spec;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      n_mant <= '0; n_exp <= '0; n_sign <= 1'b0; n_inx <= 1'b0; n_spec <= '0;
    end else begin
      n_mant <= nm[45:23];
      n_exp  <= n_exp_d;
      n_sign <= x_sign;
      n_inx  <= (|nm[22:0]) | lost;
      n_spec <= x_spec;
    end

  // ---------------------------------------------------------------- PACK
  logic [31:0] res_d;
  logic [3:0]  flg_d;

  always_comb begin
    res_d = {n_sign, n_exp[7:0], n_mant};
    flg_d = {n_sign, 1'b0, n_inx, 1'b0};
    if (n_spec.vld) begin
      res_d = n_spec.res;
      flg_d = n_spec.flg;
    end else if (n_exp >= 11'sd255) begin
      res_d = {n_sign, 8'hFF, 23'd0};
      flg_d = {n_sign, 3'b011};
    end else if (n_exp <= 11'sd0) begin
      res_d = {n_sign, 31'd0};
      flg_d = {n_sign, 3'b110};
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      done <= 1'b0; FPUResult <= '0; FPUFlags <= '0;
    end else begin
      done <= (state_q == PACK);
      if (state_q == PACK) begin
        FPUResult <= res_d;
        FPUFlags  <= flg_d;
      end
    end

  // ---------------------------------------------------------------- latency check
`ifndef SYNTHESIS
  generate
    if (LAT_CHECK) begin : g_lat
      logic [4:0] vld_pipe;
      always_ff @(posedge clk or negedge reset)
        if (!reset) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[3:0], accept};
      a_lat: assert property (@(posedge clk) disable iff (!reset) done == vld_pipe[4])
        else $error("fpu_seq: done not 5 cycles after accepted start");
    end
  endgenerate
`endif
endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: scoreboard of expected {result,flags} pushed at issue
// time and popped by the done monitor; scenario tasks check timing inline.
module tb_fpu_seq;
  localparam logic [1:0] ADD = 2'b00, MUL = 2'b01, SUB = 2'b10, RSV = 2'b11;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0]  FPUControl = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        busy, done;
  logic [31:0] FPUResult;
  logic [3:0]  FPUFlags;

  always #5 clk = ~clk;

  fpu_seq #(.LAT_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .FPUControl(FPUControl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .FPUResult(FPUResult), .FPUFlags(FPUFlags)
  );

  typedef struct packed {logic [31:0] res; logic [3:0] flg;} exp_t;
  typedef struct packed {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [3:0] flg;} vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   compared = 0, mismatched = 0;

  vec_t arith_v [10] = '{
    '{ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0010},
    '{MUL, 32'h40000000, 32'hC0400000, 32'hC0C00000, 4'b1000},
    '{SUB, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 4'b0100},
    '{RSV, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0100},
    '{ADD, 32'h40400000, 32'hBF800000, 32'h40000000, 4'b0000},
    '{SUB, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b1000},
    '{ADD, 32'h00000000, 32'h40490FDB, 32'h40490FDB, 4'b0000},
    '{MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000},
    '{MUL, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0010},
    '{ADD, 32'h00000001, 32'h00000000, 32'h00000000, 4'b0100}
  };

  vec_t spec_v [10] = '{
    '{MUL, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0011},
    '{MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0110},
    '{ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001},
    '{MUL, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001},
    '{MUL, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0001},
    '{ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000},
    '{MUL, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b1000},
    '{MUL, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b1100},
    '{SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001},
    '{ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0011}
  };

  // Scoreboard: every done pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: done=1 observed, required no done (nothing outstanding)");
      end else begin
        mon_e = sb_q.pop_front();
        if ({FPUResult, FPUFlags} !== {mon_e.res, mon_e.flg}) begin
          mismatched++;
          $display("FAIL result: got %h flags %b, required %h flags %b",
                   FPUResult, FPUFlags, mon_e.res, mon_e.flg);
        end
      end
    end
  end

  // Drive one command for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] flg);
    @(negedge clk);
    start = 1'b1; FPUControl = op; SrcA = a; SrcB = b;
    sb_q.push_back({res, flg});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; n is the cycle number it was seen in.
  task automatic wait_done(input int c0, output int n);
    n = c0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if ({busy, done, FPUResult, FPUFlags} !== 38'd0) begin
      mismatched++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h flags=%b, required all 0",
               busy, done, FPUResult, FPUFlags);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_latency();
    issue(ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000);
    for (int c = 1; c <= 5; c++) begin
      compared++;
      if (busy !== (c <= 4) || done !== (c == 5)) begin
        mismatched++;
        $display("FAIL latency_c%0d: got busy=%b done=%b, required busy=%b done=%b",
                 c, busy, done, c <= 4, c == 5);
      end
      if (c <= 4) begin
        compared++;
        if (FPUResult !== 32'd0) begin
          mismatched++;
          $display("FAIL result_hold_c%0d: got %h, required 00000000", c, FPUResult);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_arith();
    int n;
    for (int i = 0; i < 10; i++) begin
      issue(arith_v[i].op, arith_v[i].a, arith_v[i].b, arith_v[i].res, arith_v[i].flg);
      wait_done(1, n);
      compared++;
      if (n !== 5) begin
        mismatched++;
        $display("FAIL arith_lat[%0d]: done at cycle %0d, required 5", i, n);
      end
    end
  endtask

  task automatic test_special();
    int n;
    for (int i = 0; i < 10; i++) begin
      issue(spec_v[i].op, spec_v[i].a, spec_v[i].b, spec_v[i].res, spec_v[i].flg);
      wait_done(1, n);
      compared++;
      if (n !== 5) begin
        mismatched++;
        $display("FAIL special_lat[%0d]: done at cycle %0d, required 5", i, n);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int n, extra;
    issue(ADD, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    @(negedge clk);                  // cycle 2
    start = 1'b1; FPUControl = MUL; SrcA = 32'h40400000; SrcB = 32'h40400000;
    @(negedge clk);                  // cycle 3
    @(negedge clk);                  // cycle 4
    start = 1'b0;
    wait_done(4, n);
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL ignore_busy_lat: done at cycle %0d, required 5", n);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    compared++;
    if (extra !== 0) begin
      mismatched++;
      $display("FAIL ignore_busy_extra: got %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MUL, 32'h40000000, 32'hC0400000, 32'hC0C00000, 4'b1000);
    wait_done(1, n);
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL b2b_first_lat: done at cycle %0d, required 5", n);
    end
    // Still in the done cycle: launch the next command now.
    start = 1'b1; FPUControl = ADD; SrcA = 32'h3F800000; SrcB = 32'h40000000;
    sb_q.push_back({32'h40400000, 4'b0000});
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_accept: got busy=%b, required 1", busy);
    end
    wait_done(1, n);
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL b2b_second_lat: done at cycle %0d, required 5", n);
    end
  endtask

  task automatic test_abort();
    int n, extra;
    issue(MUL, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    @(negedge clk);                  // cycle 2: EXEC
    reset = 1'b0;
    #1;
    compared++;
    if ({busy, done, FPUResult, FPUFlags} !== 38'd0) begin
      mismatched++;
      $display("FAIL abort_clear: got busy=%b done=%b res=%h flags=%b, required all 0",
               busy, done, FPUResult, FPUFlags);
    end
    sb_q.delete();                   // aborted command never completes
    repeat (2) @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    compared++;
    if (extra !== 0) begin
      mismatched++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", extra);
    end
    issue(SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000);
    wait_done(1, n);
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL abort_recover_lat: done at cycle %0d, required 5", n);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_special();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    repeat (3) @(negedge clk);
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Multicycle single-precision floating-point execution unit.
- Responder side of the controller's FPUControl/FPUFlags interface: accepts a command plus two operands, sequences unpack/execute/normalize/pack, then returns FPUResult and FPUFlags with a one-cycle done pulse.
- Feeds the ResSrc result mux and the FPU flag inputs of the condition logic.

Parameters:
- LAT_CHECK, 1, when 1, a simulation-only assertion fires if done is not seen exactly 5 cycles after an accepted start.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  command valid; sampled only in IDLE
- FPUControl  input  2  00 FADD, 01 FMUL, 10 FSUB, 11 reserved
- SrcA  input  32  operand A, IEEE-754 single
- SrcB  input  32  operand B, IEEE-754 single
- busy  output  1  high from the cycle after acceptance through the PACK cycle
- done  output  1  one-cycle pulse when FPUResult/FPUFlags update
- FPUResult  output  32  registered result, held until next done
- FPUFlags  output  4  {N,Z,C,V}, registered with FPUResult

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, FPUResult=0, FPUFlags=0; internal operand registers cleared.
- Reset mid-operation: abort immediately; no done pulse for the aborted command.
- FSM states and transitions:
  - IDLE: start=1 captures FPUControl/SrcA/SrcB -> UNPACK (cycle 1).
  - UNPACK -> EXEC -> NORM -> PACK (cycles 2-4).
  - PACK: result and flags registered; done=1 on the following cycle (cycle 5), with state back in IDLE.
- Fixed latency: done high exactly 5 cycles after the start-sampling edge.
- A new start is accepted in the same cycle done is high; throughput is one op per 5 cycles.
- start while busy: ignored; no queueing.
- Unpack:
  - exp=0 treated as ±0 (denormals flushed, sign kept).
  - exp=255 with mant!=0 is NaN; exp=255 with mant=0 is ±inf.
  - Hidden bit prepended to a 24-bit significand.
- FSUB: identical to FADD with SrcB sign inverted. Reserved opcode 11: result 0x00000000, flags 0100.
- FADD:
  - Swap so |A|>=|B|; right-shift the smaller significand by the exponent difference.
  - Keep guard + sticky bits; a shift >=26 leaves only sticky.
  - Add if signs are equal, else subtract.
- FMUL:
  - 24x24 -> 48-bit product; exponent = eA+eB-127; sign = sA^sB.
- NORM:
  - Leading-zero count in one cycle; shift left or right by at most one for carry.
  - Exponent adjusted accordingly.
- Rounding: truncation (toward zero) only. Discarded nonzero bits set C (inexact).
- Special cases, evaluated in priority order:
  1. Any NaN input -> 0x7FC00000, V=1.
  2. inf-inf (effective subtract) or inf*0 -> 0x7FC00000, V=1.
  3. inf operand otherwise -> correctly signed inf, V=0.
  4. Exact zero sum -> +0x00000000.
  5. Zero operand in FMUL -> signed zero.
- Overflow: biased exponent >=255 -> signed inf, V=1, C=1.
- Underflow: biased exponent <=0 -> signed zero, C=1.
- Flags:
  - N = result sign bit, forced 0 for NaN.
  - Z = result is ±0.
  - C = inexact.
  - V = overflow or invalid.
- FPUResult/FPUFlags change only in the cycle done is high.

Test Plan:
- FADD 0x3F800000+0x3F800000, start at cycle 0 -> done at cycle 5, FPUResult 0x40000000, flags 0000; busy high in cycles 1-4.
- FADD 0x3F800000+0x33800000 -> 0x3F800000, C=1 (truncated). FMUL 0x40000000*0xC0400000 -> 0xC0C00000, flags 1000.
- FSUB 0x3FC00000-0x3FC00000 -> 0x00000000, flags 0100. Opcode 11 -> 0x00000000, flags 0100.
- FMUL 0x7F000000*0x7F000000 -> 0x7F800000, flags 0011. FMUL 0x00800000*0x00800000 -> 0x00000000, flags 0110.
- FADD 0x7F800000+0xFF800000 -> 0x7FC00000, flags 0001. FMUL 0x7FC00001*0x3F800000 -> 0x7FC00000, flags 0001. FMUL 0x7F800000*0x00000000 -> 0x7FC00000, V=1.
- Back-to-back and abort:
  - start pulsed in cycles 2-3 while busy -> ignored, single done at cycle 5.
  - start on the done cycle -> accepted, next done 5 cycles later.
  - reset driven low during EXEC -> busy, done and outputs go to 0 immediately; no done after release.
